// File: rtl/scratchpad_dma_pkg.sv
// Shared definitions for the scratchpad DMA: FSM states, fixed a-channel
// fields and the transfer word size.
package scratchpad_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RSP,
        ST_WR_REQ,
        ST_WR_RSP,
        ST_DONE
    } state_e;

    localparam int unsigned WordBytes = 4;
    localparam logic [1:0]  ASize     = 2'd2;
    localparam logic [3:0]  AMask     = 4'hF;
    localparam logic [2:0]  AParam    = 3'b000;

endpackage

// File: rtl/tlul_pkg.sv
// TL-UL channel types and integrity helpers used by bus hosts in this slice.
// Integrity is a 7-bit Hamming-style check code over the command or data word.
package tlul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'h0,
        PutPartialData = 3'h1,
        Get            = 3'h4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'h0,
        AccessAckData = 3'h1
    } tl_d_op_e;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic        a_valid;
        tl_a_op_e    a_opcode;
        logic [2:0]  a_param;
        logic [1:0]  a_size;
        logic [7:0]  a_source;
        logic [31:0] a_address;
        logic [3:0]  a_mask;
        logic [31:0] a_data;
        tl_a_user_t  a_user;
        logic        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic        d_valid;
        tl_d_op_e    d_opcode;
        logic [2:0]  d_param;
        logic [1:0]  d_size;
        logic [7:0]  d_source;
        logic [0:0]  d_sink;
        logic [31:0] d_data;
        logic [13:0] d_user;
        logic        d_error;
        logic        a_ready;
    } tl_d2h_t;

    // Check bit i covers every payload bit whose (index+1) has bit i set.
    function automatic logic [6:0] intg_code(input logic [63:0] v);
        logic [6:0] p;
        p = '0;
        for (int unsigned j = 0; j < 64; j++) begin
            for (int unsigned i = 0; i < 7; i++) begin
                if ((((j + 1) >> i) & 32'd1) == 32'd1) begin
                    p[i] = p[i] ^ v[j];
                end
            end
        end
        return p;
    endfunction

    function automatic logic [6:0] get_cmd_intg(input tl_a_op_e op,
                                                input logic [31:0] addr,
                                                input logic [3:0] mask);
        return intg_code({25'b0, op, addr, mask});
    endfunction

    function automatic logic [6:0] get_data_intg(input logic [31:0] data);
        return intg_code({32'b0, data});
    endfunction

endpackage

// File: rtl/scratchpad_dma_areq.sv
// A-channel request register: loads one request, holds every field stable
// until the handshake, and attaches command/data integrity.
module scratchpad_dma_areq
    import scratchpad_dma_pkg::*;
#(
    parameter int unsigned SourceId = 0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load_i,
    input  tlul_pkg::tl_a_op_e opcode_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    input  logic               a_ready_i,
    output tlul_pkg::tl_h2d_t  tl_a_o
);

    logic               valid_q, valid_d;
    tlul_pkg::tl_a_op_e opcode_q, opcode_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        data_q, data_d;

    // Load a new request, or retire the current one on handshake.
    always_comb begin
        valid_d  = valid_q;
        opcode_d = opcode_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (load_i) begin
            valid_d  = 1'b1;
            opcode_d = opcode_i;
            addr_d   = addr_i;
            data_d   = data_i;
        end else if (valid_q && a_ready_i) begin
            valid_d = 1'b0;
        end
    end

    // Request registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            opcode_q <= tlul_pkg::Get;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    // Drive the channel from the held registers; d_ready is owned by the FSM.
    always_comb begin
        tl_a_o                  = '0;
        tl_a_o.a_valid          = valid_q;
        tl_a_o.a_opcode         = opcode_q;
        tl_a_o.a_param          = AParam;
        tl_a_o.a_size           = ASize;
        tl_a_o.a_source         = 8'(SourceId);
        tl_a_o.a_address        = addr_q;
        tl_a_o.a_mask           = AMask;
        tl_a_o.a_data           = data_q;
        tl_a_o.a_user.cmd_intg  = tlul_pkg::get_cmd_intg(opcode_q, addr_q, AMask);
        tl_a_o.a_user.data_intg = tlul_pkg::get_data_intg(data_q);
        tl_a_o.d_ready          = 1'b0;
    end

endmodule

// File: rtl/scratchpad_dma.sv
// Scratchpad DMA: copies len_i 32-bit words from src to dst over TL-UL,
// one Get then one Put per word, with a single transaction in flight.
// Optional busy-cycle counter on cycles_o when SCRATCHPAD_DMA_PERF_EN is defined.
module scratchpad_dma
    import scratchpad_dma_pkg::*;
#(
    parameter int unsigned SourceId = 0,
    parameter int unsigned LenW     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       src_addr_i,
    input  logic [31:0]       dst_addr_i,
    input  logic [LenW-1:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output tlul_pkg::tl_h2d_t tl_h_o,
    input  tlul_pkg::tl_d2h_t tl_h_i
`ifdef SCRATCHPAD_DMA_PERF_EN
    ,
    output logic [31:0]       cycles_o
`endif
);

    state_e             state_q, state_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dst_q, dst_d;
    logic [LenW-1:0]    rem_q, rem_d;
    logic               err_q, err_d;

    logic               ld;
    tlul_pkg::tl_a_op_e ld_op;
    logic [31:0]        ld_addr;
    logic [31:0]        ld_data;
    tlul_pkg::tl_h2d_t  a_req;
    logic               a_fire;

    assign a_fire = a_req.a_valid && tl_h_i.a_ready;

    scratchpad_dma_areq #(
        .SourceId(SourceId)
    ) u_areq (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (ld),
        .opcode_i (ld_op),
        .addr_i   (ld_addr),
        .data_i   (ld_data),
        .a_ready_i(tl_h_i.a_ready),
        .tl_a_o   (a_req)
    );

    // Next-state and operand updates; a request is loaded on entry to each REQ state.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        err_d   = err_q;
        ld      = 1'b0;
        ld_op   = tlul_pkg::Get;
        ld_addr = src_q;
        ld_data = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (src_addr_i[1:0] != 2'b00 || dst_addr_i[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (len_i == '0) begin
                        err_d   = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        src_d   = src_addr_i;
                        dst_d   = dst_addr_i;
                        rem_d   = len_i;
                        ld      = 1'b1;
                        ld_op   = tlul_pkg::Get;
                        ld_addr = src_addr_i;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (a_fire) state_d = ST_RD_RSP;
            end
            ST_RD_RSP: begin
                if (tl_h_i.d_valid) begin
                    if (tl_h_i.d_error) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        ld      = 1'b1;
                        ld_op   = tlul_pkg::PutFullData;
                        ld_addr = dst_q;
                        ld_data = tl_h_i.d_data;
                        state_d = ST_WR_REQ;
                    end
                end
            end
            ST_WR_REQ: begin
                if (a_fire) state_d = ST_WR_RSP;
            end
            ST_WR_RSP: begin
                if (tl_h_i.d_valid) begin
                    if (tl_h_i.d_error) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        rem_d = rem_q - LenW'(1);
                        src_d = src_q + 32'(WordBytes);
                        dst_d = dst_q + 32'(WordBytes);
                        if (rem_q != LenW'(1)) begin
                            ld      = 1'b1;
                            ld_op   = tlul_pkg::Get;
                            ld_addr = src_q + 32'(WordBytes);
                            state_d = ST_RD_REQ;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and operand registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // Host request channel with d_ready asserted only while a response is awaited.
    always_comb begin
        tl_h_o         = a_req;
        tl_h_o.d_ready = (state_q == ST_RD_RSP) || (state_q == ST_WR_RSP);
    end

    assign busy_o = (state_q != ST_IDLE);
    assign done_o = (state_q == ST_DONE);
    assign err_o  = err_q;

`ifdef SCRATCHPAD_DMA_PERF_EN
    logic [31:0] cycles_q, cycles_d;

    // Busy-cycle counter: cleared on an accepted start, saturating.
    always_comb begin
        cycles_d = cycles_q;
        if (state_q == ST_IDLE && start_i) begin
            cycles_d = '0;
        end else if (state_q != ST_IDLE && cycles_q != '1) begin
            cycles_d = cycles_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) cycles_q <= '0;
        else       cycles_q <= cycles_d;
    end

    assign cycles_o = cycles_q;
`endif

    logic unused_d;
    assign unused_d = ^{tl_h_i.d_opcode, tl_h_i.d_param, tl_h_i.d_size,
                        tl_h_i.d_source, tl_h_i.d_sink, tl_h_i.d_user,
                        a_req.d_ready};

endmodule

// File: tb/tb_scratchpad_dma.sv
// Self-checking bench for scratchpad_dma: a TL-UL memory responder, a
// transaction-level expectation queue, per-cycle protocol checks, and
// directed transfers. Exercises cycles_o when SCRATCHPAD_DMA_PERF_EN is defined.
module tb_scratchpad_dma;
    import tlul_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src, dst;
    logic [15:0] len;
    logic        busy, done, err;
    tl_h2d_t     tl_h;
    tl_d2h_t     tl_d;
`ifdef SCRATCHPAD_DMA_PERF_EN
    logic [31:0] cycles;
`endif

    always #5 clk = ~clk;

    scratchpad_dma #(
        .SourceId(0),
        .LenW    (16)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .src_addr_i(src),
        .dst_addr_i(dst),
        .len_i     (len),
        .busy_o    (busy),
        .done_o    (done),
        .err_o     (err),
        .tl_h_o    (tl_h),
        .tl_h_i    (tl_d)
`ifdef SCRATCHPAD_DMA_PERF_EN
        ,
        .cycles_o  (cycles)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Memory behind the crossbar.
    logic [31:0] mem [bit [31:0]];

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : (32'hBAD0_0000 ^ a);
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;
    txn_t exp_q[$];

    // Responder / monitor state.
    bit          outstanding = 1'b0;
    int          gets_seen = 0, puts_seen = 0, aval_cycles = 0;
    int          err_get_abs = -1;
    int          stall_abs = 0;
    int          stall_cnt = 0;
    logic [31:0] last_put_addr = '0;
    logic [31:0] rsp_data = '0;
    bit          rsp_err = 1'b0;
    bit          prev_stall = 1'b0, prev_done = 1'b0;
    tl_h2d_t     cur, prev;
    bit          rs, hs_a, hs_d;
    txn_t        e;

    // Zero-wait memory responder plus every-cycle protocol checks.
    initial begin
        tl_d = '0;
        tl_d.a_ready = 1'b1;
        prev = '0;
        forever begin
            @(negedge clk);
            rs   = rst;
            cur  = tl_h;
            hs_a = 1'b0;
            hs_d = 1'b0;
            if (!rs) begin
                if (prev_stall) begin
                    chk("a_stable_addr_data", {cur.a_address, cur.a_data}, {prev.a_address, prev.a_data});
                    chk("a_stable_ctrl", {cur.a_valid, cur.a_opcode, cur.a_size, cur.a_mask, cur.a_source, cur.a_user},
                                         {prev.a_valid, prev.a_opcode, prev.a_size, prev.a_mask, prev.a_source, prev.a_user});
                end
                chk("d_ready", cur.d_ready, outstanding);
                chk("one_outstanding", cur.a_valid && outstanding, 0);
                if (cur.a_valid || outstanding) chk("busy_active", busy, 1);
                chk("done_single_pulse", done && prev_done, 0);
                if (cur.a_valid) aval_cycles++;
                hs_a = cur.a_valid && tl_d.a_ready;
                hs_d = tl_d.d_valid && cur.d_ready;
                if (hs_a) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_txn: got op %0h addr 0x%0h, expected no request", cur.a_opcode, cur.a_address);
                    end else begin
                        e = exp_q.pop_front();
                        chk("txn_opcode", cur.a_opcode, e.op);
                        chk("txn_addr", cur.a_address, e.addr);
                        if (e.op == PutFullData) chk("txn_data", cur.a_data, e.data);
                    end
                    chk("txn_size_mask_src", {cur.a_size, cur.a_mask, cur.a_source}, {2'd2, 4'hF, 8'd0});
                    if (cur.a_opcode == Get) begin
                        gets_seen++;
                        rsp_data = rd(cur.a_address);
                        rsp_err  = (gets_seen == err_get_abs);
                    end else begin
                        puts_seen++;
                        mem[cur.a_address] = cur.a_data;
                        last_put_addr = cur.a_address;
                        rsp_data = '0;
                        rsp_err  = 1'b0;
                    end
                end
            end
            prev_stall = !rs && cur.a_valid && !tl_d.a_ready;
            prev       = cur;
            prev_done  = !rs && done;
            @(posedge clk);
            #1;
            if (rs) begin
                outstanding = 1'b0;
                stall_cnt   = 0;
            end else begin
                if (hs_d) outstanding = 1'b0;
                if (hs_a) begin
                    outstanding = 1'b1;
                    stall_cnt   = 0;
                end
            end
            tl_d.d_valid  = outstanding;
            tl_d.d_data   = outstanding ? rsp_data : '0;
            tl_d.d_error  = outstanding && rsp_err;
            tl_d.d_opcode = AccessAckData;
            if (tl_h.a_valid && tl_h.a_opcode == PutFullData && puts_seen + 1 == stall_abs && stall_cnt < 5) begin
                tl_d.a_ready = 1'b0;
                stall_cnt++;
            end else begin
                tl_d.a_ready = 1'b1;
            end
        end
    end

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(posedge clk);
        #1;
        src = s; dst = d; len = l; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // One transfer against the model: expected transactions, latency, final state.
    task automatic run_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            input int err_get, input int stall_put, input bit poke,
                            output int dcyc, output int nput);
        bit          misal;
        int          ncopy, exp_done, nbusy, g0, p0, av0;
        logic [31:0] expw[$];
        misal = (s[1:0] != 2'b00) || (d[1:0] != 2'b00);
        if (!misal) begin
            for (int i = 0; i < int'(l); i++) begin
                exp_q.push_back('{op: Get, addr: s + 32'(4 * i), data: '0});
                if (err_get != 0 && i + 1 == err_get) break;
                exp_q.push_back('{op: PutFullData, addr: d + 32'(4 * i), data: rd(s + 32'(4 * i))});
            end
        end
        ncopy = misal ? 0 : (err_get != 0 ? err_get - 1 : int'(l));
        for (int i = 0; i < ncopy; i++) expw.push_back(rd(s + 32'(4 * i)));
        if (misal || l == 0) exp_done = 1;
        else if (err_get != 0) exp_done = 4 * (err_get - 1) + 3;
        else exp_done = 4 * int'(l) + 1;
        if (stall_put != 0 && stall_put <= ncopy) exp_done += 5;
        g0 = gets_seen; p0 = puts_seen; av0 = aval_cycles;
        err_get_abs = (err_get != 0) ? gets_seen + err_get : -1;
        stall_abs   = (stall_put != 0) ? puts_seen + stall_put : 0;
        pulse_start(s, d, l);
        dcyc = 0;
        nbusy = 0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (cyc == 1) chk("err_after_start", err, misal);
            if (poke && cyc == 2) begin
                src = s + 32'd1; len = 16'd0; start = 1'b1;
            end
            if (poke && cyc == 3) start = 1'b0;
            if (done) begin
                dcyc = cyc;
                break;
            end
        end
        if (dcyc == 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            chk("idle_after_done", {done, busy}, 2'b00);
            chk("done_latency", dcyc, exp_done);
            chk("busy_cycles", nbusy, exp_done);
            chk("err_final", err, misal || err_get != 0);
            chk("txns_left", exp_q.size(), 0);
            chk("get_count", gets_seen - g0, misal ? 0 : (err_get != 0 ? err_get : int'(l)));
            chk("put_count", puts_seen - p0, ncopy);
            for (int i = 0; i < ncopy; i++) chk("dst_word", rd(d + 32'(4 * i)), expw[i]);
            if (misal || l == 0) chk("no_a_valid", aval_cycles - av0, 0);
`ifdef SCRATCHPAD_DMA_PERF_EN
            chk("cycles_o", cycles, nbusy);
`endif
        end
        exp_q.delete();
        stall_abs = 0;
        err_get_abs = -1;
        nput = puts_seen - p0;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk(nm, {busy, done, err, tl_h.a_valid, tl_h.d_ready}, 5'b0);
`ifdef SCRATCHPAD_DMA_PERF_EN
        chk("reset_cycles_o", cycles, 0);
`endif
    endtask

    // Reset while a Put is being presented (held in WR_REQ by backpressure).
    task automatic reset_mid_write();
        bit found;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{op: Get, addr: 32'h0001_0000 + 32'(4 * i), data: '0});
            exp_q.push_back('{op: PutFullData, addr: 32'h0004_0000 + 32'(4 * i), data: rd(32'h0001_0000 + 32'(4 * i))});
        end
        stall_abs = puts_seen + 1;
        pulse_start(32'h0001_0000, 32'h0004_0000, 16'd3);
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (tl_h.a_valid && tl_h.a_opcode == PutFullData) begin
                found = 1'b1;
                break;
            end
        end
        chk("reached_wr_req", found, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("reset_mid_xfer");
        rst = 1'b0;
        exp_q.delete();
        stall_abs = 0;
    endtask

    int dc, np;

    initial begin
        rst = 1'b1; start = 1'b0; src = '0; dst = '0; len = '0;
        mem[32'h0001_0000] = 32'hCAFE_0001;
        mem[32'h0001_0004] = 32'hCAFE_0002;
        mem[32'h0001_0008] = 32'hCAFE_0003;
        mem[32'h0001_000C] = 32'hCAFE_0004;
        mem[32'h0005_0000] = 32'h5555_0001;
        mem[32'h0005_0004] = 32'h5555_0002;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst = 1'b0;

        // Plain copy of three words.
        run_xfer(32'h0001_0000, 32'h0002_0000, 16'd3, 0, 0, 1'b0, dc, np);
        chk("copy_latency_lit", dc, 13);
        chk("copy_word0_lit", rd(32'h0002_0000), 32'hCAFE_0001);
        chk("copy_word1_lit", rd(32'h0002_0004), 32'hCAFE_0002);
        chk("copy_word2_lit", rd(32'h0002_0008), 32'hCAFE_0003);

        // Backpressure on the second Put, with a start_i poke while busy.
        run_xfer(32'h0001_0000, 32'h0002_8000, 16'd3, 0, 2, 1'b1, dc, np);
        chk("stall_latency_lit", dc, 18);

        // Error on the second Get of four.
        run_xfer(32'h0001_0000, 32'h0003_0000, 16'd4, 2, 0, 1'b0, dc, np);
        chk("err_puts_lit", np, 1);
        chk("err_sticky", err, 1);

        // Next valid start clears the error.
        run_xfer(32'h0001_0004, 32'h0003_8000, 16'd1, 0, 0, 1'b0, dc, np);

        // Zero length, misaligned source, misaligned destination.
        run_xfer(32'h0001_0000, 32'h0002_0000, 16'd0, 0, 0, 1'b0, dc, np);
        chk("len0_latency_lit", dc, 1);
        run_xfer(32'h0001_0002, 32'h0002_0000, 16'd2, 0, 0, 1'b0, dc, np);
        run_xfer(32'h0001_0000, 32'h0002_0001, 16'd2, 0, 0, 1'b0, dc, np);

        // Destination wraps past the top of the address space.
        run_xfer(32'h0005_0000, 32'hFFFF_FFFC, 16'd2, 0, 0, 1'b0, dc, np);
        chk("wrap_addr_lit", last_put_addr, 32'h0000_0000);
        chk("wrap_data_lit", rd(32'h0000_0000), 32'h5555_0002);

        // Reset mid-transfer, then a clean zero-wait copy of two words.
        reset_mid_write();
        run_xfer(32'h0001_0000, 32'h0006_0000, 16'd2, 0, 0, 1'b0, dc, np);
        chk("len2_latency_lit", dc, 9);
`ifdef SCRATCHPAD_DMA_PERF_EN
        chk("perf_cycles_lit", cycles, 9);
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/scratchpad_dma.md
SCRATCHPAD_DMA -- requirements
Module: scratchpad_dma

Interface
REQ-001 Parameter SourceId, default 0: a_source value on every request.
REQ-002 Parameter LenW, default 16: width of the word-count input.
REQ-003 clk_i  input  1  system clock; all logic on the rising edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  starts a transfer; sampled only in IDLE.
REQ-006 src_addr_i  input  32  source byte address, word aligned.
REQ-007 dst_addr_i  input  32  destination byte address, word aligned.
REQ-008 len_i  input  LenW  number of 32-bit words to copy.
REQ-009 busy_o  output  1  high while not in IDLE.
REQ-010 done_o  output  1  one-cycle pulse when a transfer ends, including error or zero-length.
REQ-011 err_o  output  1  sticky error flag; cleared by the next accepted start_i.
REQ-012 tl_h_o  output  tlul_pkg::tl_h2d_t  TL-UL host request channel toward the crossbar.
REQ-013 tl_h_i  input  tlul_pkg::tl_d2h_t  TL-UL host response channel from the crossbar.
REQ-014 cycles_o  output  32  busy-cycle count; present only under SCRATCHPAD_DMA_PERF_EN.

Function
REQ-015 States: IDLE, RD_REQ, RD_RSP, WR_REQ, WR_RSP, DONE.
REQ-016 IDLE + start_i with len_i>0 and both addresses aligned: latch the operands, clear err_o, go to RD_REQ; a_valid rises on the next cycle.
REQ-017 IDLE + start_i with len_i==0: go to DONE with no bus traffic and err_o=0.
REQ-018 IDLE + start_i with either address[1:0]!=0: set err_o, go to DONE, no bus traffic.
REQ-019 RD_REQ: a_valid=1, a_opcode=Get, a_address=current src, a_size=2, a_mask=4'hF, a_source=SourceId; on a_ready go to RD_RSP.
REQ-020 WR_REQ: a_valid=1, a_opcode=PutFullData, a_address=current dst, a_data=captured read word, a_size=2, a_mask=4'hF; on a_ready go to WR_RSP.
REQ-021 While a_valid=1, all a-channel fields shall stay stable until a_ready is seen.
REQ-022 d_ready=1 only in RD_RSP and WR_RSP; d_valid in any other state is ignored.
REQ-023 RD_RSP + d_valid: capture d_data and go to WR_REQ.
REQ-024 WR_RSP + d_valid: decrement remaining, add 4 to src and dst (32-bit modulo wrap); go to RD_REQ if remaining becomes nonzero, else DONE.
REQ-025 d_error=1 on any response: set err_o, abandon the remaining words, go to DONE; when the failed response is a read, no write is issued.
REQ-026 At most one outstanding transaction at a time.
REQ-027 DONE: done_o=1 for exactly one cycle, then IDLE; start_i is ignored in DONE and in every busy state.
REQ-028 Per word, minimum latency is 4 cycles with zero-wait a_ready and d_valid.
REQ-029 Integrity fields in a_user come from the codebase command and data integrity generators; d-channel integrity is not checked.

Reset
REQ-030 rst_i forces IDLE and drives busy_o=0, done_o=0, err_o=0, a_valid=0, d_ready=0, cycles_o=0, and clears all operand registers.
REQ-031 rst_i mid-transfer aborts immediately; system reset shall also reset the crossbar and targets, so a dropped request is not an error.

Configuration
REQ-032 With SCRATCHPAD_DMA_PERF_EN defined, cycles_o counts the cycles busy_o=1, clears on an accepted start, and saturates at 32'hFFFF_FFFF.
REQ-033 Without SCRATCHPAD_DMA_PERF_EN, the cycles_o port and its counter are absent.

Structure
REQ-034 A shared package scratchpad_dma_pkg holds the state enum, the opcode-independent a-channel defaults and the word-size constant.
REQ-035 One sub-module, scratchpad_dma_areq, registers and holds the a-channel fields and generates integrity; the FSM and counters live in the top level.

Verification
REQ-036 Copy: src=0x0001_0000, dst=0x0002_0000, len=3 with memory model words A,B,C -> 3 Gets then 3 Puts alternating; dst holds A,B,C; one done_o pulse; err_o=0.
REQ-037 Backpressure: a_ready held low 5 cycles on the second Put -> a-channel fields stable throughout; data correct.
REQ-038 Error: d_error=1 on the second Get with len=4 -> exactly 1 Put issued; err_o=1; done_o pulses; the next valid start clears err_o.
REQ-039 Edges: len=0 -> done_o on the next cycle with no a_valid; src=0x0001_0002 -> err_o=1 with no a_valid; dst=0xFFFF_FFFC with len=2 -> second Put to 0x0000_0000.
REQ-040 Reset: rst_i asserted in WR_REQ -> IDLE next cycle, all outputs at reset values; start_i during busy is ignored.
REQ-041 Perf: with SCRATCHPAD_DMA_PERF_EN, a zero-wait len=2 copy -> cycles_o equals the measured busy_o-high cycle count.
